// File: rtl/decoder_pkg.sv
// Shared mode and FSM encodings for the index decoder pipeline.
// Pure types and constants; no timing or flow-control behaviour of its own.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_pipe_if.sv
// Request/beat bundle between a requester and decoder_pipe.
// Valid/ready on both sides; master drives requests and out_ready, slave is the decoder.
interface decoder_pipe_if #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2**IN_W
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_idx;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_err;

  modport master (
    output in_valid, in_idx, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_err
  );

  modport slave (
    input  in_valid, in_idx, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_last, out_err
  );
endinterface

// File: rtl/onehot_gen.sv
// Combinational index -> one-hot / thermometer pattern with out-of-range flag.
// Zero latency, no flow control; out-of-range indices yield an all-zero pattern.
module onehot_gen
  import decoder_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  idx,
  input  mode_e            mode,
  output logic [OUT_W-1:0] pattern,
  output logic             err
);

  localparam logic [IN_W:0] OUT_W_L = (IN_W+1)'(OUT_W);

  always_comb begin
    err     = ({1'b0, idx} >= OUT_W_L);
    pattern = '0;
    if (!err) begin
      for (int i = 0; i < OUT_W; i++) begin
        pattern[i] = (mode == MODE_THERMO) ? (IN_W'(i) <= idx) : (IN_W'(i) == idx);
      end
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Index decoder (DECODE/THERMO/SCAN) with one registered output stage, 1-cycle latency.
// Backpressure: beat holds while out_ready=0; in_ready drops while stalled or scanning.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int OUT_W = 2**IN_W
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_pipe_if.slave  bus
);

  localparam logic [IN_W-1:0] LAST_IDX = IN_W'(OUT_W-1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  scan_cnt_q;
  logic             out_valid_q, out_last_q, out_err_q;
  logic [OUT_W-1:0] out_data_q;

  logic             in_fire, out_fire;
  logic [IN_W-1:0]  gen_idx;
  mode_e            gen_mode;
  logic [OUT_W-1:0] gen_pat;
  logic             gen_err;

  logic             load, load_last, clr_valid, cnt_load, cnt_inc;

  assign out_fire     = out_valid_q & bus.out_ready;
  assign bus.in_ready = rst_n & (state_q == ST_IDLE) & (~out_valid_q | bus.out_ready);
  assign in_fire      = bus.in_valid & bus.in_ready;

  // scan_cnt_q tracks the bit currently presented; the generator builds the next one
  assign gen_idx  = (state_q == ST_SCAN) ? scan_cnt_q + IN_W'(1) : bus.in_idx;
  assign gen_mode = (state_q == ST_SCAN) ? MODE_DECODE : mode_e'(bus.in_mode);

  onehot_gen #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_gen (
    .idx     (gen_idx),
    .mode    (gen_mode),
    .pattern (gen_pat),
    .err     (gen_err)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_last = 1'b1;
    clr_valid = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          load = 1'b1;
          if (gen_mode == MODE_SCAN && !gen_err && bus.in_idx != LAST_IDX) begin
            load_last = 1'b0;
            cnt_load  = 1'b1;
            state_d   = ST_SCAN;
          end
        end else if (out_fire) begin
          clr_valid = 1'b1;
        end
      end
      ST_SCAN: begin
        if (out_fire) begin
          if (out_last_q) begin
            clr_valid = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            load      = 1'b1;
            cnt_inc   = 1'b1;
            load_last = (gen_idx == LAST_IDX);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      scan_cnt_q  <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gen_pat;
        out_last_q  <= load_last;
        out_err_q   <= gen_err;
      end else if (clr_valid) begin
        out_valid_q <= 1'b0;
      end
      if (cnt_load)     scan_cnt_q <= bus.in_idx;
      else if (cnt_inc) scan_cnt_q <= scan_cnt_q + IN_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_err   = out_err_q;

endmodule
